dsu_engine: RTL and testbench

Parametrised disjoint-set (union-find) engine: successor to the single-pass bulk-load union-find block. It accepts a stream of FIND and UNION commands over a valid/ready handshake and performs true two-root union by size. Optional path compression is a compile-time choice. Each command returns root, component size and merge status on a response channel, and a live component count is maintained. It sits between the edge/pair producer and the answer-accumulation logic in the puzzle pipelines.

---
 rtl/dsu_engine.sv | 273 +++++++++++++++++++++++++++
 tb/tb_dsu_engine.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsu_engine.sv
// ============================================================================
// Module   : dsu_engine
// Brief    : Union-find engine (FIND / UNION by size) over a valid/ready
//            command/response stream. Optional path compression is enabled
//            by defining DSU_PATH_COMPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsu_engine #(
  parameter int MAX_NODE_COUNT = 2000,
  localparam int IDX_W  = $clog2(MAX_NODE_COUNT),
  localparam int SIZE_W = $clog2(MAX_NODE_COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [IDX_W-1:0]  cmd_u,
  input  logic [IDX_W-1:0]  cmd_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDX_W-1:0]  rsp_root,
  output logic [SIZE_W-1:0] rsp_size,
  output logic              rsp_merged,
  output logic              rsp_err,
  output logic [SIZE_W-1:0] num_components,
  output logic              init_done
);

`ifdef DSU_PATH_COMPRESS_EN
  localparam logic c_path_compress = 1'b1;
`else
  localparam logic c_path_compress = 1'b0;
`endif

  localparam int                c_entry_w    = 1 + IDX_W + SIZE_W;
  localparam logic [IDX_W:0]    c_nodes      = (IDX_W+1)'(MAX_NODE_COUNT);
  localparam logic [IDX_W-1:0]  c_last_idx   = IDX_W'(MAX_NODE_COUNT - 1);
  localparam logic [IDX_W-1:0]  c_idx_one    = IDX_W'(1);
  localparam logic [SIZE_W-1:0] c_size_one   = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] c_hop_limit  = SIZE_W'(MAX_NODE_COUNT - 1);
  localparam logic [SIZE_W-1:0] c_node_total = SIZE_W'(MAX_NODE_COUNT);

  localparam logic [2:0] c_st_init   = 3'd0;
  localparam logic [2:0] c_st_idle   = 3'd1;
  localparam logic [2:0] c_st_find_u = 3'd2;
  localparam logic [2:0] c_st_comp_u = 3'd3;
  localparam logic [2:0] c_st_find_v = 3'd4;
  localparam logic [2:0] c_st_comp_v = 3'd5;
  localparam logic [2:0] c_st_link   = 3'd6;
  localparam logic [2:0] c_st_resp   = 3'd7;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [c_entry_w-1:0]  r_table [MAX_NODE_COUNT];

  logic [IDX_W-1:0]      r_init_idx;
  logic                  r_op;
  logic [IDX_W-1:0]      r_u;
  logic [IDX_W-1:0]      r_v;
  logic [IDX_W-1:0]      r_cur;
  logic [SIZE_W-1:0]     r_hops;
  logic [IDX_W-1:0]      r_root_u;
  logic [IDX_W-1:0]      r_root_v;
  logic [SIZE_W-1:0]     r_size_u;
  logic [SIZE_W-1:0]     r_size_v;
  logic [SIZE_W-1:0]     r_num_comp;
  logic                  r_size_wr_pend;

  logic [c_entry_w-1:0]  w_rd_entry;
  logic                  w_rd_is_root;
  logic [IDX_W-1:0]      w_rd_parent;
  logic [SIZE_W-1:0]     w_rd_size;
  logic                  w_walk_end;
  logic                  w_do_comp;
  logic                  w_range_err;
  logic                  w_roots_equal;
  logic                  w_u_wins;
  logic                  w_wr_en;
  logic [IDX_W-1:0]      w_wr_addr;
  logic [c_entry_w-1:0]  w_wr_data;

  // Single read port: every walk step looks at the node addressed by r_cur.
  assign w_rd_entry    = r_table[r_cur];
  assign w_rd_is_root  = w_rd_entry[c_entry_w-1];
  assign w_rd_parent   = w_rd_entry[c_entry_w-2 -: IDX_W];
  assign w_rd_size     = w_rd_entry[SIZE_W-1:0];
  assign w_walk_end    = w_rd_is_root || (r_hops == c_hop_limit);
  assign w_do_comp     = c_path_compress && (r_hops != '0);
  assign w_range_err   = ({1'b0, cmd_u} >= c_nodes) || (cmd_op && ({1'b0, cmd_v} >= c_nodes));
  assign w_roots_equal = (r_root_u == r_root_v);
  assign w_u_wins      = (r_size_u >= r_size_v);
  assign num_components = r_num_comp;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_init;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_init:   if (r_init_idx == c_last_idx) w_state_nxt = c_st_idle;
      c_st_idle:   if (cmd_valid) w_state_nxt = w_range_err ? c_st_resp : c_st_find_u;
      c_st_find_u: if (w_walk_end) begin
                     if (w_do_comp)  w_state_nxt = c_st_comp_u;
                     else if (r_op)  w_state_nxt = c_st_find_v;
                     else            w_state_nxt = c_st_resp;
                   end
      c_st_comp_u: if (r_hops == c_size_one) w_state_nxt = r_op ? c_st_find_v : c_st_resp;
      c_st_find_v: if (w_walk_end) w_state_nxt = w_do_comp ? c_st_comp_v : c_st_link;
      c_st_comp_v: if (r_hops == c_size_one) w_state_nxt = c_st_link;
      c_st_link:   w_state_nxt = c_st_resp;
      c_st_resp:   if (rsp_ready) w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_init;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == c_st_idle);
    rsp_valid = (r_state == c_st_resp);
    init_done = (r_state != c_st_init);
  end

  // Write port. LINK re-parents the losing root; the surviving root's new
  // size is written in the first RESP cycle so only one write is ever needed.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    case (r_state)
      c_st_init: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_init_idx;
        w_wr_data = {1'b1, r_init_idx, c_size_one};
      end
      c_st_comp_u: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_cur;
        w_wr_data = {1'b0, r_root_u, w_rd_size};
      end
      c_st_comp_v: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_cur;
        w_wr_data = {1'b0, r_root_v, w_rd_size};
      end
      c_st_link: begin
        if (!w_roots_equal) begin
          w_wr_en = 1'b1;
          if (w_u_wins) begin
            w_wr_addr = r_root_v;
            w_wr_data = {1'b0, r_root_u, r_size_v};
          end else begin
            w_wr_addr = r_root_u;
            w_wr_data = {1'b0, r_root_v, r_size_u};
          end
        end
      end
      c_st_resp: begin
        if (r_size_wr_pend) begin
          w_wr_en   = 1'b1;
          w_wr_addr = rsp_root;
          w_wr_data = {1'b1, rsp_root, rsp_size};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_table[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_idx     <= '0;
      r_num_comp     <= c_node_total;
      r_op           <= 1'b0;
      r_u            <= '0;
      r_v            <= '0;
      r_cur          <= '0;
      r_hops         <= '0;
      r_root_u       <= '0;
      r_root_v       <= '0;
      r_size_u       <= '0;
      r_size_v       <= '0;
      r_size_wr_pend <= 1'b0;
      rsp_root       <= '0;
      rsp_size       <= '0;
      rsp_merged     <= 1'b0;
      rsp_err        <= 1'b0;
    end else begin
      case (r_state)
        c_st_init: begin
          r_init_idx <= r_init_idx + c_idx_one;
          r_num_comp <= c_node_total;
        end
        c_st_idle: begin
          if (cmd_valid) begin
            r_op       <= cmd_op;
            r_u        <= cmd_u;
            r_v        <= cmd_v;
            r_cur      <= cmd_u;
            r_hops     <= '0;
            rsp_merged <= 1'b0;
            rsp_err    <= w_range_err;
            rsp_root   <= '0;
            rsp_size   <= '0;
          end
        end
        c_st_find_u: begin
          if (w_walk_end) begin
            r_root_u <= r_cur;
            r_size_u <= w_rd_size;
            rsp_root <= r_cur;
            rsp_size <= w_rd_size;
            if (w_do_comp) begin
              r_cur <= r_u;
            end else begin
              r_cur  <= r_v;
              r_hops <= '0;
            end
          end else begin
            r_cur  <= w_rd_parent;
            r_hops <= r_hops + c_size_one;
          end
        end
        c_st_comp_u: begin
          if (r_hops == c_size_one) begin
            r_cur  <= r_v;
            r_hops <= '0;
          end else begin
            r_cur  <= w_rd_parent;
            r_hops <= r_hops - c_size_one;
          end
        end
        c_st_find_v: begin
          if (w_walk_end) begin
            r_root_v <= r_cur;
            r_size_v <= w_rd_size;
            if (w_do_comp) r_cur <= r_v;
          end else begin
            r_cur  <= w_rd_parent;
            r_hops <= r_hops + c_size_one;
          end
        end
        c_st_comp_v: begin
          r_cur  <= w_rd_parent;
          r_hops <= r_hops - c_size_one;
        end
        c_st_link: begin
          if (!w_roots_equal) begin
            rsp_merged     <= 1'b1;
            r_num_comp     <= r_num_comp - c_size_one;
            rsp_size       <= r_size_u + r_size_v;
            rsp_root       <= w_u_wins ? r_root_u : r_root_v;
            r_size_wr_pend <= 1'b1;
          end else begin
            rsp_root <= r_root_u;
            rsp_size <= r_size_u;
          end
        end
        c_st_resp: r_size_wr_pend <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsu_engine.sv
// ============================================================================
// Module   : tb_dsu_engine
// Brief    : Self-checking bench for dsu_engine against a union-find model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsu_engine;

  localparam int NA = 8;
  localparam int NB = 9;
  localparam int IA = $clog2(NA);
  localparam int SA = $clog2(NA + 1);
  localparam int SB = $clog2(NB + 1);
`ifdef DSU_PATH_COMPRESS_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_op = 1'b0;
  logic [3:0] cmd_u = '0;
  logic [3:0] cmd_v = '0;
  logic rsp_ready = 1'b0;

  always #5 clk = ~clk;

  logic a_cmd_ready, a_rsp_valid, a_merged, a_err, a_init;
  logic [IA-1:0] a_root;
  logic [SA-1:0] a_size, a_comp;
  logic b_cmd_ready, b_rsp_valid, b_merged, b_err, b_init;
  logic [3:0] b_root;
  logic [SB-1:0] b_size, b_comp;

  dsu_engine #(.MAX_NODE_COUNT(NA)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready),
    .cmd_op(cmd_op), .cmd_u(cmd_u[IA-1:0]), .cmd_v(cmd_v[IA-1:0]),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
    .rsp_root(a_root), .rsp_size(a_size), .rsp_merged(a_merged), .rsp_err(a_err),
    .num_components(a_comp), .init_done(a_init)
  );

  dsu_engine #(.MAX_NODE_COUNT(NB)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready),
    .cmd_op(cmd_op), .cmd_u(cmd_u), .cmd_v(cmd_v),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
    .rsp_root(b_root), .rsp_size(b_size), .rsp_merged(b_merged), .rsp_err(b_err),
    .num_components(b_comp), .init_done(b_init)
  );

  // Whichever engine is selected is observed through these.
  logic cmd_ready_m, rsp_valid_m, merged_m, err_m, init_m;
  int   root_m, size_m, comp_m;
  always_comb begin
    if (sel) begin
      cmd_ready_m = b_cmd_ready; rsp_valid_m = b_rsp_valid; merged_m = b_merged;
      err_m = b_err; init_m = b_init;
      root_m = int'(b_root); size_m = int'(b_size); comp_m = int'(b_comp);
    end else begin
      cmd_ready_m = a_cmd_ready; rsp_valid_m = a_rsp_valid; merged_m = a_merged;
      err_m = a_err; init_m = a_init;
      root_m = int'(a_root); size_m = int'(a_size); comp_m = int'(a_comp);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  int m_n, m_cnt;
  int m_par [16];
  int m_sz  [16];
  int exp_root, exp_size, exp_lat;
  bit exp_merged, exp_err;

  function automatic void m_reset(input int n);
    m_n = n;
    m_cnt = n;
    for (int i = 0; i < 16; i++) begin
      m_par[i] = i;
      m_sz[i]  = 1;
    end
  endfunction

  function automatic int m_find(input int x, output int depth);
    int r, y, nx;
    r = x;
    depth = 0;
    while (m_par[r] != r) begin
      r = m_par[r];
      depth++;
    end
    if (PC) begin
      y = x;
      while (m_par[y] != y) begin
        nx = m_par[y];
        m_par[y] = r;
        y = nx;
      end
    end
    return r;
  endfunction

  function automatic void m_cmd(input bit op, input int u, input int v);
    int ru, rv, du, dv;
    exp_merged = 1'b0;
    exp_err    = 1'b0;
    if (u >= m_n || (op && v >= m_n)) begin
      exp_err = 1'b1; exp_root = 0; exp_size = 0; exp_lat = 1;
      return;
    end
    ru = m_find(u, du);
    if (!op) begin
      exp_root = ru; exp_size = m_sz[ru];
      exp_lat  = 1 + (du + 1) + (PC ? du : 0);
      return;
    end
    rv = m_find(v, dv);
    exp_lat = 1 + (du + 1) + (PC ? du : 0) + (dv + 1) + (PC ? dv : 0) + 1;
    if (ru == rv) begin
      exp_root = ru;
    end else begin
      if (m_sz[ru] >= m_sz[rv]) begin
        m_par[rv] = ru; m_sz[ru] += m_sz[rv]; exp_root = ru;
      end else begin
        m_par[ru] = rv; m_sz[rv] += m_sz[ru]; exp_root = rv;
      end
      exp_merged = 1'b1;
      m_cnt--;
    end
    exp_size = m_sz[exp_root];
  endfunction

  // ---------------- stimulus helpers ----------------
  int got_root, got_size, got_lat, got_comp;
  bit got_merged, got_err;

  task automatic send_cmd(input bit op, input int u, input int v);
    int n;
    bit got;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_u = 4'(u); cmd_v = 4'(v);
    n = 0;
    while (!cmd_ready_m && n < 300) begin
      @(negedge clk);
      n++;
    end
    got_lat = -1;
    if (!cmd_ready_m) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid_m) begin
        got = 1'b1;
        got_lat = k;
      end
    end
    got_root = root_m; got_size = size_m; got_merged = merged_m;
    got_err = err_m; got_comp = comp_m;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic do_init(output int cycles);
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    while (!cmd_ready_m && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    sel = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({cmd_ready_m, rsp_valid_m, merged_m, err_m, init_m} !== 5'b0 ||
        root_m !== 0 || size_m !== 0 || comp_m !== NA) begin
      n_bad++;
      $display("FAIL reset_values: ready=%0b valid=%0b merged=%0b err=%0b init=%0b root=%0d size=%0d comp=%0d required all 0 and comp=%0d",
               cmd_ready_m, rsp_valid_m, merged_m, err_m, init_m, root_m, size_m, comp_m, NA);
    end
    do_init(cyc);
    n_cmp++;
    if (cyc !== NA || init_m !== 1'b1 || comp_m !== NA) begin
      n_bad++;
      $display("FAIL init_length: cycles=%0d init_done=%0b comp=%0d required cycles=%0d init_done=1 comp=%0d",
               cyc, init_m, comp_m, NA, NA);
    end
    m_reset(NA);
  endtask

  task automatic test_find();
    m_cmd(1'b0, 5, 0);
    send_cmd(1'b0, 5, 0);
    ack_rsp();
    n_cmp++;
    if (got_root !== 5 || got_size !== 1 || got_merged !== 1'b0 || got_err !== 1'b0 || got_lat !== 2 || exp_lat !== 2) begin
      n_bad++;
      $display("FAIL find5: root=%0d size=%0d merged=%0b err=%0b lat=%0d required root=5 size=1 merged=0 err=0 lat=2",
               got_root, got_size, got_merged, got_err, got_lat);
    end
  endtask

  task automatic test_union();
    int tbl [5][2] = '{'{1, 2}, '{2, 1}, '{3, 4}, '{5, 4}, '{1, 5}};
    for (int i = 0; i < 5; i++) begin
      m_cmd(1'b1, tbl[i][0], tbl[i][1]);
      send_cmd(1'b1, tbl[i][0], tbl[i][1]);
      ack_rsp();
      n_cmp++;
      if (got_root !== exp_root || got_size !== exp_size || got_merged !== exp_merged ||
          got_err !== exp_err || got_lat !== exp_lat || got_comp !== m_cnt) begin
        n_bad++;
        $display("FAIL union_%0d_%0d: root=%0d size=%0d merged=%0b err=%0b lat=%0d comp=%0d required root=%0d size=%0d merged=%0b err=%0b lat=%0d comp=%0d",
                 tbl[i][0], tbl[i][1], got_root, got_size, got_merged, got_err, got_lat, got_comp,
                 exp_root, exp_size, exp_merged, exp_err, exp_lat, m_cnt);
      end
    end
  endtask

  // Node 2 now sits two hops below root 3.
  task automatic test_compress();
    int lat1, lat2;
    bit shorter_or_equal;
    for (int i = 0; i < 2; i++) begin
      m_cmd(1'b0, 2, 0);
      send_cmd(1'b0, 2, 0);
      ack_rsp();
      if (i == 0) lat1 = got_lat; else lat2 = got_lat;
      n_cmp++;
      if (got_root !== 3 || got_size !== 5 || got_lat !== exp_lat) begin
        n_bad++;
        $display("FAIL deep_find_%0d: root=%0d size=%0d lat=%0d required root=3 size=5 lat=%0d",
                 i, got_root, got_size, got_lat, exp_lat);
      end
    end
    shorter_or_equal = PC ? (lat2 < lat1) : (lat2 == lat1);
    n_cmp++;
    if (!shorter_or_equal) begin
      n_bad++;
      $display("FAIL compress_latency: first=%0d second=%0d required %s", lat1, lat2,
               PC ? "second shorter" : "equal");
    end
  endtask

  task automatic test_error();
    sel = 1'b1;
    m_reset(NB);
    send_cmd(1'b1, 2, 9);
    n_cmp++;
    if (got_err !== 1'b1 || got_root !== 0 || got_size !== 0 || got_merged !== 1'b0 ||
        got_lat !== 1 || got_comp !== NB) begin
      n_bad++;
      $display("FAIL err_union_2_9: err=%0b root=%0d size=%0d merged=%0b lat=%0d comp=%0d required err=1 root=0 size=0 merged=0 lat=1 comp=%0d",
               got_err, got_root, got_size, got_merged, got_lat, got_comp, NB);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid_m !== 1'b1 || cmd_ready_m !== 1'b0 || err_m !== 1'b1 ||
          root_m !== 0 || size_m !== 0 || merged_m !== 1'b0) begin
        n_bad++;
        $display("FAIL err_hold_%0d: valid=%0b ready=%0b err=%0b root=%0d size=%0d merged=%0b required valid=1 ready=0 err=1 root=0 size=0 merged=0",
                 k, rsp_valid_m, cmd_ready_m, err_m, root_m, size_m, merged_m);
      end
    end
    ack_rsp();
    send_cmd(1'b0, 2, 0);
    ack_rsp();
    n_cmp++;
    if (got_root !== 2 || got_size !== 1 || got_err !== 1'b0 || got_comp !== NB) begin
      n_bad++;
      $display("FAIL err_no_side_effect: root=%0d size=%0d err=%0b comp=%0d required root=2 size=1 err=0 comp=%0d",
               got_root, got_size, got_err, got_comp, NB);
    end
  endtask

  task automatic test_random(input int iters, input int umax);
    bit op;
    int u, v;
    for (int i = 0; i < iters; i++) begin
      op = 1'($urandom_range(0, 1));
      u  = int'($urandom_range(0, umax));
      v  = int'($urandom_range(0, umax));
      m_cmd(op, u, v);
      send_cmd(op, u, v);
      ack_rsp();
      n_cmp++;
      if (got_root !== exp_root || got_size !== exp_size || got_merged !== exp_merged ||
          got_err !== exp_err || got_lat !== exp_lat || got_comp !== m_cnt) begin
        n_bad++;
        $display("FAIL random_%0d op=%0b u=%0d v=%0d: root=%0d size=%0d merged=%0b err=%0b lat=%0d comp=%0d required root=%0d size=%0d merged=%0b err=%0b lat=%0d comp=%0d",
                 i, op, u, v, got_root, got_size, got_merged, got_err, got_lat, got_comp,
                 exp_root, exp_size, exp_merged, exp_err, exp_lat, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int u, cyc, n;
    sel = 1'b0;
    u = 0;
    for (int i = NA - 1; i >= 0; i--) if (m_par[i] == i) u = i;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_u = 4'(u); cmd_v = 4'((u + 1) % NA);
    n = 0;
    while (!cmd_ready_m && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid_m !== 1'b0 || cmd_ready_m !== 1'b0 || init_m !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_in_find_v: valid=%0b ready=%0b init=%0b required 0 0 0",
               rsp_valid_m, cmd_ready_m, init_m);
    end
    do_init(cyc);
    m_reset(NA);
    n_cmp++;
    if (cyc !== NA || comp_m !== NA) begin
      n_bad++;
      $display("FAIL reinit: cycles=%0d comp=%0d required cycles=%0d comp=%0d", cyc, comp_m, NA, NA);
    end
    send_cmd(1'b0, 1, 0);
    n_cmp++;
    if (got_root !== 1 || got_size !== 1 || got_lat !== 2) begin
      n_bad++;
      $display("FAIL find1_after_rst: root=%0d size=%0d lat=%0d required root=1 size=1 lat=2",
               got_root, got_size, got_lat);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid_m !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_in_resp: valid=%0b required 0", rsp_valid_m);
    end
    do_init(cyc);
    m_reset(NA);
    n_cmp++;
    if (cyc !== NA) begin
      n_bad++;
      $display("FAIL reinit2: cycles=%0d required %0d", cyc, NA);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_find();
    test_union();
    test_compress();
    test_error();
    test_random(30, 10);
    test_reset_mid_op();
    test_random(40, NA - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
